sha256_msg_schedule: RTL

- Message-schedule expander sitting directly downstream of the memory manager. It shares that block's 8-bit word-addressed, 32-bit RAM port.
- Once the ROM copy is complete, H0..H7 are at 0..7 and K0..K63 are at 64..127. The host then writes message words W0..W15 at W_BASE..W_BASE+15.
- On START, this block reads back from RAM, computes W16..W63 and writes them to W_BASE+16..W_BASE+63. The compression stage consumes them from there.

---
 rtl/sha256_msg_schedule.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule expander: reads W0..W15 back from the shared RAM,
// then generates W16..W63 one word per six cycles and writes them back.
module sha256_msg_schedule #(
    parameter int unsigned W_BASE  = 128,
    parameter int unsigned N_WORDS = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ROM_READY,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        MEM_RE,
    output logic        MEM_WR,
    output logic [7:0]  MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    typedef enum logic [2:0] {
        IDLE, RD16, RD15, RD7, RD2, SUM, WB, FIN
    } state_t;

    localparam logic [7:0] BASE    = 8'(W_BASE);
    localparam logic [5:0] T_FIRST = 6'd16;
    localparam logic [5:0] T_LAST  = 6'(N_WORDS - 1);

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  t_q, t_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        re_q, re_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] c_q, c_d;
    logic [31:0] d_q, d_d;
    logic [7:0]  w_addr;

    assign w_addr = BASE + {2'b00, t_q};

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        re_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (START && ROM_READY) begin
                    state_d = RD16;
                    t_d     = T_FIRST;
                    busy_d  = 1'b1;
                    re_d    = 1'b1;
                    addr_d  = BASE;
                end
            end
            RD16: begin
                state_d = RD15;
                re_d    = 1'b1;
                addr_d  = w_addr - 8'd15;
            end
            RD15: begin
                a_d     = MEM_RDATA;
                state_d = RD7;
                re_d    = 1'b1;
                addr_d  = w_addr - 8'd7;
            end
            RD7: begin
                b_d     = MEM_RDATA;
                state_d = RD2;
                re_d    = 1'b1;
                addr_d  = w_addr - 8'd2;
            end
            RD2: begin
                c_d     = MEM_RDATA;
                state_d = SUM;
            end
            SUM: begin
                d_d     = MEM_RDATA;
                state_d = WB;
                wr_d    = 1'b1;
                addr_d  = w_addr;
            end
            WB: begin
                if (t_q == T_LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    // next word starts at W[t+1-16]
                    t_d     = t_q + 6'd1;
                    state_d = RD16;
                    re_d    = 1'b1;
                    addr_d  = w_addr - 8'd15;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            t_q     <= T_FIRST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            c_q     <= 32'd0;
            d_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            re_q    <= re_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
        end
    end

    // Write data is a pure function of the operand flops, so it is 0 after reset.
    assign MEM_WDATA = sig1(d_q) + c_q + sig0(b_q) + a_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign MEM_RE    = re_q;
    assign MEM_WR    = wr_q;
    assign MEM_ADDR  = addr_q;

endmodule
